awgn_clt_gen: RTL and testbench

- Parametrised multi-channel Gaussian noise source; a lighter, scalable successor to the Box-Muller generator.
- Each of NUM_CH channels owns a three-component Tausworthe URNG.
- Each channel approximates a Gaussian by the central limit theorem: sum 2^LOG2_K uniform draws, remove the mean, scale by a runtime sigma.
- Outputs all channels in lockstep behind a valid/ready handshake, with seed reload and saturation control.

---
 rtl/awgn_clt_gen.sv | 173 +++++++++++++++++
 tb/tb_awgn_clt_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/awgn_clt_gen.sv
// awgn_clt_gen: multi-channel Gaussian noise source based on the central limit theorem.
// Each channel runs a taus88 uniform generator. It sums K = 2^LOG2_K draws, removes the
// mean K*2^15, scales the result by iSigma, arithmetically shifts right by SHIFT and
// presents it on oNoise. All channels run in lockstep behind a valid/ready handshake.
//
// Optional feature: define AWGN_SAT_EN to clamp each result symmetrically to
// +/-(2^(OUT_W-1)-1). When it is undefined, the result simply wraps to OUT_W bits.
//
// Ports:
//   iClk         clock
//   iRst         synchronous active-high reset
//   iSeed_load   reload seeds and restart accumulation (accepted in any state)
//   iSeed        per channel {s3,s2,s1}, 32 bits each, channel 0 in the LSBs
//   iSigma       unsigned noise scale, sampled in the SCALE cycle
//   iReady       downstream accepts oNoise
//   oNoise       signed samples, OUT_W bits per channel, channel 0 in the LSBs
//   oValid       oNoise holds a fresh sample
//   oSample_cnt  number of accepted samples, wrapping
module awgn_clt_gen #(
  parameter int NUM_CH = 2,
  parameter int LOG2_K = 4,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 16
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    iSeed_load,
  input  logic [NUM_CH*96-1:0]    iSeed,
  input  logic [15:0]             iSigma,
  input  logic                    iReady,
  output logic [NUM_CH*OUT_W-1:0] oNoise,
  output logic                    oValid,
  output logic [31:0]             oSample_cnt
);

  localparam int K     = 1 << LOG2_K;
  localparam int ACC_W = 16 + LOG2_K;
  localparam int C_W   = 17 + LOG2_K;
  localparam int P_W   = C_W + 17;

  typedef enum logic [1:0] {SEED, ACC, SCALE, VALID} stateT;

  stateT             state;
  stateT             nextState;
  logic [LOG2_K-1:0] drawCnt;
  logic [31:0]       sampleCnt;
  logic              handshake;

  assign handshake   = (state == VALID) && iReady;
  assign oValid      = (state == VALID);
  assign oSample_cnt = sampleCnt;

  // State register. Reset always returns to SEED, so a fresh seed load is required.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= SEED;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic. A seed load overrides every other transition, including a
  // pending handshake in VALID, which discards the sample that is being held.
  always_comb begin
    nextState = state;
    case (state)
      SEED:    nextState = SEED;
      ACC:     if (&drawCnt) nextState = SCALE;
      SCALE:   nextState = VALID;
      VALID:   if (iReady) nextState = ACC;
      default: nextState = SEED;
    endcase
    if (iSeed_load) nextState = ACC;
  end

  // Draw counter. It wraps to zero naturally after the K-th draw, so it is already
  // cleared when accumulation restarts after a handshake.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      drawCnt <= '0;
    end else if (iSeed_load) begin
      drawCnt <= '0;
    end else if (state == ACC) begin
      drawCnt <= drawCnt + LOG2_K'(1);
    end
  end

  // Accepted-sample counter. A seed load in the same cycle as a handshake wins, and
  // in that case the sample is not counted.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      sampleCnt <= '0;
    end else if (!iSeed_load && handshake) begin
      sampleCnt <= sampleCnt + 32'd1;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : gChan
    logic [31:0]              s1, s2, s3;
    logic [31:0]              t1, t2, t3;
    logic [31:0]              n1, n2, n3;
    logic [31:0]              urn;
    logic [ACC_W-1:0]         acc;
    logic signed [C_W-1:0]    centred;
    logic signed [P_W-1:0]    product;
    logic signed [P_W-1:0]    shifted;
    logic signed [OUT_W-1:0]  scaled;
    logic signed [OUT_W-1:0]  noiseReg;

    // taus88 recurrences, one step per ACC cycle; urn is the output of the new state.
    assign t1  = ((s1 << 13) ^ s1) >> 19;
    assign n1  = ((s1 & 32'hFFFF_FFFE) << 12) ^ t1;
    assign t2  = ((s2 << 2) ^ s2) >> 25;
    assign n2  = ((s2 & 32'hFFFF_FFF8) << 4) ^ t2;
    assign t3  = ((s3 << 3) ^ s3) >> 11;
    assign n3  = ((s3 & 32'hFFFF_FFF0) << 17) ^ t3;
    assign urn = n1 ^ n2 ^ n3;

    // The sum of K 16-bit uniforms has mean K*2^15. Subtracting it gives a signed
    // value that is one bit wider than the accumulator.
    assign centred = $signed({1'b0, acc}) - $signed(C_W'(K << 15));
    assign product = centred * $signed({1'b0, iSigma});
    assign shifted = product >>> SHIFT;

    // Reduce to OUT_W bits, either by saturating or by two's-complement wrap.
`ifdef AWGN_SAT_EN
    localparam logic signed [P_W-1:0] SAT_MAX = (P_W'(1) << (OUT_W - 1)) - P_W'(1);
    localparam logic signed [P_W-1:0] SAT_MIN = -SAT_MAX;
    always_comb begin
      scaled = OUT_W'(shifted);
      if (shifted > SAT_MAX) begin
        scaled = OUT_W'(SAT_MAX);
      end else if (shifted < SAT_MIN) begin
        scaled = OUT_W'(SAT_MIN);
      end
    end
`else
    assign scaled = OUT_W'(shifted);
`endif

    // Per-channel URNG state, accumulator and output register. The URNG state only
    // advances in ACC, so it is frozen while a sample is being scaled or held.
    always_ff @(posedge iClk) begin
      if (iRst) begin
        s1       <= '0;
        s2       <= '0;
        s3       <= '0;
        acc      <= '0;
        noiseReg <= '0;
      end else if (iSeed_load) begin
        s1  <= iSeed[ch*96 +: 32]      | 32'h2;
        s2  <= iSeed[ch*96 + 32 +: 32] | 32'h8;
        s3  <= iSeed[ch*96 + 64 +: 32] | 32'h10;
        acc <= '0;
      end else begin
        case (state)
          ACC: begin
            s1  <= n1;
            s2  <= n2;
            s3  <= n3;
            acc <= acc + ACC_W'(urn[31:16]);
          end
          SCALE:   noiseReg <= scaled;
          VALID:   if (iReady) acc <= '0;
          default: ;
        endcase
      end
    end

    assign oNoise[ch*OUT_W +: OUT_W] = noiseReg;
  end

endmodule

// File: tb/tb_awgn_clt_gen.sv
// tb_awgn_clt_gen: randomized scoreboard bench for awgn_clt_gen.
// Two instances are driven from the same inputs. The default one uses OUT_W=16 and
// SHIFT=16. The narrow one uses OUT_W=8 and SHIFT=0, which exercises wrap and
// saturation (AWGN_SAT_EN).
// The reference model works on a timeline: a load or a handshake at edge n schedules
// the next sample for edge n+K+2. At the edge before that, the model draws K taus88
// outputs directly, computes the sample and pushes it onto a queue. A separate monitor
// pops the queue when oValid rises and checks the outputs on every falling edge.
`timescale 1ns/1ps
module tb_awgn_clt_gen;

  localparam int NUM_CH = 2;
  localparam int LOG2_K = 4;
  localparam int K      = 1 << LOG2_K;

  typedef struct {
    logic [NUM_CH*16-1:0] a;
    logic [NUM_CH*8-1:0]  b;
  } expT;

  logic                 iClk = 1'b0;
  logic                 iRst = 1'b1;
  logic                 iSeed_load = 1'b0;
  logic [NUM_CH*96-1:0] iSeed = '0;
  logic [15:0]          iSigma = '0;
  logic                 iReady = 1'b0;
  logic [NUM_CH*16-1:0] oNoise;
  logic                 oValid;
  logic [31:0]          oSample_cnt;
  logic [NUM_CH*8-1:0]  oNoiseB;
  logic                 oValidB;
  logic [31:0]          oSample_cntB;

  int          vectors = 0;
  int          misses  = 0;
  longint      cyc = 0;
  longint      validEdge = 0;
  bit          pending = 0;
  bit          prevValid = 0;
  logic [31:0] mCnt = '0;
  logic [31:0] mCntB = '0;
  logic [31:0] m1 [NUM_CH];
  logic [31:0] m2 [NUM_CH];
  logic [31:0] m3 [NUM_CH];
  expT         q[$];
  expT         curExp = '{a: '0, b: '0};

  awgn_clt_gen #(.NUM_CH(NUM_CH), .LOG2_K(LOG2_K), .OUT_W(16), .SHIFT(16)) dut (
    .iClk(iClk), .iRst(iRst), .iSeed_load(iSeed_load), .iSeed(iSeed), .iSigma(iSigma),
    .iReady(iReady), .oNoise(oNoise), .oValid(oValid), .oSample_cnt(oSample_cnt)
  );

  awgn_clt_gen #(.NUM_CH(NUM_CH), .LOG2_K(LOG2_K), .OUT_W(8), .SHIFT(0)) dutB (
    .iClk(iClk), .iRst(iRst), .iSeed_load(iSeed_load), .iSeed(iSeed), .iSigma(iSigma),
    .iReady(iReady), .oNoise(oNoiseB), .oValid(oValidB), .oSample_cnt(oSample_cntB)
  );

  always #5 iClk = ~iClk;

  // Compares one observed value with the expected one and keeps the counters.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drives one clock cycle of inputs on the falling edge.
  task automatic applyStimulus(input bit rst, input bit load, input logic [NUM_CH*96-1:0] seed,
                               input logic [15:0] sigma, input bit ready);
    @(negedge iClk);
    iRst       = rst;
    iSeed_load = load;
    iSeed      = seed;
    iSigma     = sigma;
    iReady     = ready;
  endtask

  // Idles with iReady low until oValid rises. If the budget expires, this counts as a failure.
  task automatic waitValid(input int budget);
    int n = 0;
    while (!oValid && n < budget) begin
      applyStimulus(1'b0, 1'b0, iSeed, iSigma, 1'b0);
      n++;
    end
    vectors++;
    if (!oValid) begin
      misses++;
      $display("[TB] FAIL waitValid: oValid still 0 after %0d cycles", budget);
    end
  endtask

  function automatic logic [NUM_CH*96-1:0] mkSeed(input logic [31:0] a, input logic [31:0] b,
                                                  input logic [31:0] c);
    return {c, b, a, c, b, a};
  endfunction

  function automatic longint clampTo(input longint r, input int w);
    longint mx;
    mx = (longint'(1) << (w - 1)) - 1;
    if (r > mx) return mx;
    if (r < -mx) return -mx;
    return r;
  endfunction

  // Draws K taus88 outputs per channel and builds the expected words for both instances.
  task automatic computeSample();
    expT         e;
    longint      sum, c, p, rA, rB;
    logic [31:0] t, u;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sum = 0;
      for (int d = 0; d < K; d++) begin
        t = ((m1[ch] << 13) ^ m1[ch]) >> 19;
        m1[ch] = ((m1[ch] & 32'hFFFF_FFFE) << 12) ^ t;
        t = ((m2[ch] << 2) ^ m2[ch]) >> 25;
        m2[ch] = ((m2[ch] & 32'hFFFF_FFF8) << 4) ^ t;
        t = ((m3[ch] << 3) ^ m3[ch]) >> 11;
        m3[ch] = ((m3[ch] & 32'hFFFF_FFF0) << 17) ^ t;
        u = m1[ch] ^ m2[ch] ^ m3[ch];
        sum += longint'(u[31:16]);
      end
      c  = sum - longint'(K) * 32768;
      p  = c * longint'(iSigma);
      rA = p >>> 16;
      rB = p;
`ifdef AWGN_SAT_EN
      rA = clampTo(rA, 16);
      rB = clampTo(rB, 8);
`endif
      e.a[ch*16 +: 16] = rA[15:0];
      e.b[ch*8 +: 8]   = rB[7:0];
    end
    q.push_back(e);
  endtask

  // Timeline reference model, evaluated on the same edges the DUT samples.
  always @(posedge iClk) begin
    cyc++;
    if (iRst) begin
      pending = 0;
      mCnt    = '0;
      mCntB   = '0;
      curExp  = '{a: '0, b: '0};
      q.delete();
    end else if (iSeed_load) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        m1[ch] = iSeed[ch*96 +: 32]      | 32'h2;
        m2[ch] = iSeed[ch*96 + 32 +: 32] | 32'h8;
        m3[ch] = iSeed[ch*96 + 64 +: 32] | 32'h10;
      end
      pending   = 1;
      validEdge = cyc + K + 2;
    end else if (pending) begin
      if (cyc == validEdge - 1) begin
        computeSample();
      end else if (cyc >= validEdge && iReady) begin
        mCnt++;
        mCntB++;
        validEdge = cyc + K + 2;
      end
    end
  end

  // Monitor: pops an expected sample whenever the DUT presents a new one, and checks
  // the handshake and counter outputs on every cycle.
  always @(negedge iClk) begin
    bit mValid;
    mValid = pending && (cyc + 1 >= validEdge);
    if (oValid && !prevValid) begin
      if (q.size() == 0) begin
        vectors++;
        misses++;
        $display("[TB] FAIL unexpectedSample: oValid rose with no sample scheduled at t=%0t", $time);
      end else begin
        curExp = q.pop_front();
      end
    end
    checkOutput("oValid", 64'(oValid), 64'(mValid));
    checkOutput("oValidB", 64'(oValidB), 64'(mValid));
    checkOutput("oNoise", 64'(oNoise), 64'(curExp.a));
    checkOutput("oNoiseB", 64'(oNoiseB), 64'(curExp.b));
    checkOutput("oSample_cnt", 64'(oSample_cnt), 64'(mCnt));
    checkOutput("oSample_cntB", 64'(oSample_cntB), 64'(mCntB));
    prevValid = oValid;
  end

  initial begin
    logic [NUM_CH*96-1:0] sd;
    logic [15:0]          sig;
    sd  = '0;
    sig = '0;

    repeat (3) applyStimulus(1'b1, 1'b0, sd, sig, 1'b0);
    repeat (100) applyStimulus(1'b0, 1'b0, sd, sig, 1'($urandom_range(0, 1)));

    sd = mkSeed(32'd2, 32'd8, 32'd16);
    applyStimulus(1'b0, 1'b1, sd, 16'h0000, 1'b1);
    repeat (60) applyStimulus(1'b0, 1'b0, sd, 16'h0000, 1'b1);

    sd  = '0;
    sig = 16'h4000;
    applyStimulus(1'b0, 1'b1, sd, sig, 1'b1);
    repeat (60) applyStimulus(1'b0, 1'b0, sd, sig, 1'b1);

    waitValid(100);
    repeat (50) applyStimulus(1'b0, 1'b0, sd, sig, 1'b0);
    applyStimulus(1'b0, 1'b0, sd, sig, 1'b1);
    repeat (5) applyStimulus(1'b0, 1'b0, sd, sig, 1'b0);

    waitValid(100);
    applyStimulus(1'b0, 1'b1, sd, sig, 1'b1);
    repeat (40) applyStimulus(1'b0, 1'b0, sd, sig, 1'b1);

    applyStimulus(1'b0, 1'b1, sd, sig, 1'b1);
    repeat (5) applyStimulus(1'b0, 1'b0, sd, sig, 1'b1);
    applyStimulus(1'b1, 1'b0, sd, sig, 1'b1);
    repeat (30) applyStimulus(1'b0, 1'b0, sd, sig, 1'b1);

    sd  = mkSeed($urandom, $urandom, $urandom);
    sig = 16'hFFFF;
    applyStimulus(1'b0, 1'b1, sd, sig, 1'b1);
    repeat (80) applyStimulus(1'b0, 1'b0, sd, sig, 1'b1);

    waitValid(100);
    applyStimulus(1'b0, 1'b0, sd, sig, 1'b1);
    #1;
    force dut.sampleCnt = 32'hFFFF_FFFF;
    mCnt = 32'hFFFF_FFFF;
    #1;
    release dut.sampleCnt;
    waitValid(100);
    applyStimulus(1'b0, 1'b0, sd, sig, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, sd, sig, 1'b0);

    for (int i = 0; i < 600; i++) begin
      bit ld;
      ld = ($urandom_range(0, 60) == 0);
      if (ld) sd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 2))
          0:       sig = 16'($urandom);
          1:       sig = 16'hFFFF;
          default: sig = 16'h4000;
        endcase
      end
      applyStimulus(1'b0, ld, sd, sig, ($urandom_range(0, 3) != 0));
    end

    repeat (2) applyStimulus(1'b0, 1'b0, sd, sig, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
